// File: rtl/acc_pkg.sv
// Shared definitions for the psum accumulation sequencer: default geometry,
// derived loop lengths and the sequencer state encoding.
package acc_pkg;

    localparam int unsigned IN_W      = 6;
    localparam int unsigned K_W       = 3;
    localparam int unsigned OUT_W     = 4;
    localparam int unsigned ADDR_BW   = 14;
    localparam int unsigned PSUM_BASE = 0;

    localparam int unsigned LEN_NIJ  = IN_W * IN_W;
    localparam int unsigned LEN_KIJ  = K_W * K_W;
    localparam int unsigned LEN_ONIJ = OUT_W * OUT_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } acc_state_e;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_bw(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/acc_seq_if.sv
// Control/SRAM-side bundle of the accumulation sequencer. The sequencer is the
// master (drives the psum SRAM read port and SFU strobes); the system side is
// the slave (issues start/hold and consumes the strobes).
interface acc_seq_if #(
    parameter int unsigned addr_bw = 14
);
    logic               start;
    logic               hold;
    logic               CEN_pmem;
    logic               WEN_pmem;
    logic [addr_bw-1:0] A_pmem;
    logic               acc;
    logic               sfu_clr;
    logic               out_valid;
    logic [7:0]         onij_idx;
    logic               busy;
    logic               done;

    modport master (
        input  start, hold,
        output CEN_pmem, WEN_pmem, A_pmem, acc, sfu_clr, out_valid, onij_idx, busy, done
    );

    modport slave (
        output start, hold,
        input  CEN_pmem, WEN_pmem, A_pmem, acc, sfu_clr, out_valid, onij_idx, busy, done
    );
endinterface

// File: rtl/acc_addr_gen.sv
// Psum read-address generator. Walks kernel offsets (ki,kj) inside one output
// pixel and output pixels (orow,ocol) across a pass, using only incremental
// adds: a kj step moves one kij plane plus one column, a ki step moves one kij
// plane plus one row minus the kj columns already walked.
module acc_addr_gen
    import acc_pkg::*;
#(
    parameter int unsigned in_w      = IN_W,
    parameter int unsigned k_w       = K_W,
    parameter int unsigned out_w     = OUT_W,
    parameter int unsigned addr_bw   = ADDR_BW,
    parameter int unsigned psum_base = PSUM_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_pix,
    input  logic               step_kij,
    input  logic               step_onij,
    output logic [addr_bw-1:0] addr,
    output logic               last_kij,
    output logic               last_onij
);
    localparam int unsigned KBW = cnt_bw(k_w);
    localparam int unsigned OBW = cnt_bw(out_w);

    localparam logic [KBW-1:0]     K_MAX     = KBW'(k_w - 1);
    localparam logic [KBW-1:0]     K_ONE     = KBW'(1);
    localparam logic [OBW-1:0]     O_MAX     = OBW'(out_w - 1);
    localparam logic [OBW-1:0]     O_ONE     = OBW'(1);
    localparam logic [addr_bw-1:0] BASE      = addr_bw'(psum_base);
    localparam logic [addr_bw-1:0] STEP_KJ   = addr_bw'(in_w * in_w + 1);
    localparam logic [addr_bw-1:0] STEP_KI   = addr_bw'(in_w * in_w + in_w - k_w + 1);
    localparam logic [addr_bw-1:0] STEP_OCOL = addr_bw'(1);
    localparam logic [addr_bw-1:0] STEP_OROW = addr_bw'(in_w - out_w + 1);

    logic [KBW-1:0]     ki_r;
    logic [KBW-1:0]     kj_r;
    logic [OBW-1:0]     orow_r;
    logic [OBW-1:0]     ocol_r;
    logic [addr_bw-1:0] pix_base_r;
    logic [addr_bw-1:0] addr_r;

    assign addr      = addr_r;
    assign last_kij  = (ki_r == K_MAX) && (kj_r == K_MAX);
    assign last_onij = (orow_r == O_MAX) && (ocol_r == O_MAX);

    // Kernel-offset counters and the live read address within one pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            ki_r   <= '0;
            kj_r   <= '0;
            addr_r <= '0;
        end else if (clr_pix) begin
            ki_r   <= '0;
            kj_r   <= '0;
            addr_r <= pix_base_r;
        end else if (step_kij) begin
            if (kj_r == K_MAX) begin
                kj_r   <= '0;
                ki_r   <= ki_r + K_ONE;
                addr_r <= addr_r + STEP_KI;
            end else begin
                kj_r   <= kj_r + K_ONE;
                addr_r <= addr_r + STEP_KJ;
            end
        end else begin
            ki_r   <= ki_r;
            kj_r   <= kj_r;
            addr_r <= addr_r;
        end
    end

    // Output-pixel counters and the kij0 address of the current pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            orow_r     <= '0;
            ocol_r     <= '0;
            pix_base_r <= BASE;
        end else if (step_onij) begin
            if (ocol_r == O_MAX) begin
                ocol_r <= '0;
                if (orow_r == O_MAX) begin
                    orow_r     <= '0;
                    pix_base_r <= BASE;
                end else begin
                    orow_r     <= orow_r + O_ONE;
                    pix_base_r <= pix_base_r + STEP_OROW;
                end
            end else begin
                ocol_r     <= ocol_r + O_ONE;
                pix_base_r <= pix_base_r + STEP_OCOL;
            end
        end else begin
            orow_r     <= orow_r;
            ocol_r     <= ocol_r;
            pix_base_r <= pix_base_r;
        end
    end

endmodule

// File: rtl/acc_seq.sv
// Psum accumulation sequencer. For every output pixel: clear the SFU, issue
// len_kij psum reads, strobe acc once per returned word (reads have one cycle
// latency, hence the trailing DRAIN strobe), then flag the finished output.
// Every output is a flop; next values are decided from the current state.
module acc_seq
    import acc_pkg::*;
#(
    parameter int unsigned in_w      = IN_W,
    parameter int unsigned k_w       = K_W,
    parameter int unsigned out_w     = OUT_W,
    parameter int unsigned addr_bw   = ADDR_BW,
    parameter int unsigned psum_base = PSUM_BASE
) (
    input  logic      clk,
    input  logic      reset,
    acc_seq_if.master bus
);
    acc_state_e         state_r, state_nxt_s;
    logic               cen_r, cen_nxt_s;
    logic               acc_r, acc_nxt_s;
    logic               clr_r, clr_nxt_s;
    logic               ov_r, ov_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic [7:0]         idx_r, idx_nxt_s;
    logic               clr_pix_s, step_kij_s, step_onij_s;
    logic               last_kij_s, last_onij_s;
    logic [addr_bw-1:0] addr_s;

    acc_addr_gen #(
        .in_w      (in_w),
        .k_w       (k_w),
        .out_w     (out_w),
        .addr_bw   (addr_bw),
        .psum_base (psum_base)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clr_pix   (clr_pix_s),
        .step_kij  (step_kij_s),
        .step_onij (step_onij_s),
        .addr      (addr_s),
        .last_kij  (last_kij_s),
        .last_onij (last_onij_s)
    );

    // Next state, next registered outputs and address-generator steps.
    always_comb begin
        state_nxt_s = state_r;
        cen_nxt_s   = 1'b1;
        acc_nxt_s   = 1'b0;
        clr_nxt_s   = 1'b0;
        ov_nxt_s    = 1'b0;
        done_nxt_s  = 1'b0;
        busy_nxt_s  = busy_r;
        idx_nxt_s   = idx_r;
        clr_pix_s   = 1'b0;
        step_kij_s  = 1'b0;
        step_onij_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_CLR;
                    busy_nxt_s  = 1'b1;
                    idx_nxt_s   = 8'd0;
                    clr_nxt_s   = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_CLR: begin
                // Output boundary: the only place a stall is accepted.
                if (bus.hold) begin
                    clr_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_RD;
                    cen_nxt_s   = 1'b0;
                    clr_pix_s   = 1'b1;
                end
            end
            ST_RD: begin
                acc_nxt_s = 1'b1;
                if (last_kij_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    cen_nxt_s   = 1'b0;
                    step_kij_s  = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = ST_OUT;
                ov_nxt_s    = 1'b1;
                if (last_onij_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            ST_OUT: begin
                step_onij_s = 1'b1;
                if (last_onij_s) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_CLR;
                    idx_nxt_s   = idx_r + 8'd1;
                    clr_nxt_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cen_r   <= 1'b1;
            acc_r   <= 1'b0;
            clr_r   <= 1'b0;
            ov_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            idx_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cen_r   <= cen_nxt_s;
            acc_r   <= acc_nxt_s;
            clr_r   <= clr_nxt_s;
            ov_r    <= ov_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Writes to the psum SRAM belong to the OFIFO path; this port only reads.
    assign bus.WEN_pmem  = 1'b1;
    assign bus.CEN_pmem  = cen_r;
    assign bus.A_pmem    = addr_s;
    assign bus.acc       = acc_r;
    assign bus.sfu_clr   = clr_r;
    assign bus.out_valid = ov_r;
    assign bus.onij_idx  = idx_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: psum SRAM + SFU environment model, reference addresses and
// sums computed straight from the convolution indexing, randomized data/stalls.
module tb_acc_seq;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic reset;

    acc_seq_if #(.addr_bw(ADDR_BW)) bus ();

    acc_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int mem [1024];
    int rdata   = 0;
    int sfu_sum = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Psum SRAM with one-cycle read latency feeding an accumulate/clear SFU.
    always @(posedge clk) begin
        if (!bus.CEN_pmem) rdata <= mem[bus.A_pmem[9:0]];
        if (bus.sfu_clr) sfu_sum <= 0;
        else if (bus.acc) sfu_sum <= sfu_sum + rdata;
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_addr(input int onij, input int kij);
        int orow, ocol, ki, kj;
        orow = onij / OUT_W;
        ocol = onij % OUT_W;
        ki   = kij / K_W;
        kj   = kij % K_W;
        return (PSUM_BASE + kij * LEN_NIJ + (orow + ki) * IN_W + ocol + kj) % (1 << ADDR_BW);
    endfunction

    task automatic check_idle(input string tag);
        chk_eq(tag, {bus.A_pmem, bus.onij_idx, bus.CEN_pmem, bus.WEN_pmem, bus.acc,
                     bus.sfu_clr, bus.out_valid, bus.busy, bus.done}, 64'b110_0000);
    endtask

    // One accumulation pass. hold_clr_on: pixel whose CLR is stalled hold_len
    // cycles; hold_rd_on: pixel whose reads see hold; s0/s1: cycles with a
    // stray start; rst_on: pixel reset at its kij=4 read; rnd_hold: random hold
    // outside CLR (must be ignored).
    task automatic run_pass(input int hold_clr_on, input int hold_len, input int hold_rd_on,
                            input int s0, input int s1, input int rst_on, input bit rnd_hold);
        int  exp_q[$];
        int  exp_sum [LEN_ONIJ];
        int  cyc, out_cnt, acc_cnt, rd_run, rd_total, hold_left, done_cyc;
        int  first_rd, first_acc, first_ov, exp_cycles;
        bit  hold_used, held_prev, rd_hold, aborted;
        for (int o = 0; o < LEN_ONIJ; o++) begin
            exp_sum[o] = 0;
            for (int k = 0; k < LEN_KIJ; k++) begin
                exp_q.push_back(ref_addr(o, k));
                exp_sum[o] += mem[ref_addr(o, k) % 1024];
            end
        end
        exp_cycles = LEN_ONIJ * (LEN_KIJ + 3) + ((hold_clr_on >= 0) ? hold_len : 0);
        out_cnt = 0; acc_cnt = 0; rd_run = 0; rd_total = 0; hold_left = 0;
        done_cyc = -1; first_rd = -1; first_acc = -1; first_ov = -1;
        hold_used = 0; held_prev = 0; aborted = 0;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        chk_eq("clr_after_start", {bus.busy, bus.sfu_clr, bus.CEN_pmem, bus.onij_idx}, 64'h700);

        while (done_cyc < 0 && !aborted && cyc < 400) begin
            chk_eq("busy", bus.busy, 1);
            if (held_prev)
                chk_eq("hold_in_clr", {bus.sfu_clr, bus.CEN_pmem, bus.acc}, 3'b110);
            if (!bus.CEN_pmem) begin
                if (first_rd < 0) first_rd = cyc;
                rd_run++;
                rd_total++;
                if (exp_q.size() > 0)
                    chk_eq($sformatf("addr_o%0d_r%0d", out_cnt, rd_run), bus.A_pmem, exp_q.pop_front());
                else
                    chk_eq("read_total", rd_total, LEN_ONIJ * LEN_KIJ);
            end else if (rd_run > 0) begin
                chk_eq("contig_reads", rd_run, LEN_KIJ);
                rd_run = 0;
            end
            if (bus.acc) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (bus.out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                chk_eq("out_idx", bus.onij_idx, out_cnt);
                chk_eq($sformatf("sum_o%0d", out_cnt), sfu_sum, exp_sum[out_cnt % LEN_ONIJ]);
                chk_eq("acc_pulses", acc_cnt, LEN_KIJ);
                acc_cnt = 0;
                out_cnt++;
            end
            if (bus.done) done_cyc = cyc;

            // Inputs for the next edge.
            if (hold_clr_on >= 0 && !hold_used && bus.sfu_clr && bus.onij_idx == 8'(hold_clr_on)) begin
                hold_used = 1;
                hold_left = hold_len;
            end
            rd_hold   = (!bus.CEN_pmem && bus.onij_idx == 8'(hold_rd_on));
            held_prev = (hold_left > 0);
            bus.hold  = (hold_left > 0) || rd_hold ||
                        (rnd_hold && !bus.sfu_clr && $urandom_range(0, 3) == 0);
            if (hold_left > 0) hold_left--;
            bus.start = (cyc == s0) || (cyc == s1);
            if (rst_on >= 0 && !bus.CEN_pmem && bus.onij_idx == 8'(rst_on) && rd_run == 5)
                reset = 1'b1;
            tick();
            cyc++;
            if (reset) begin
                reset = 1'b0;
                bus.start = 1'b0;
                bus.hold = 1'b0;
                check_idle("after_mid_reset");
                aborted = 1;
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;

        if (aborted) begin
            chk_eq("no_done_on_reset", done_cyc, -1);
            tick();
            check_idle("idle_after_reset");
        end else begin
            chk_eq("done_cycle", done_cyc, exp_cycles);
            chk_eq("outputs", out_cnt, LEN_ONIJ);
            chk_eq("first_rd_cycle", first_rd, 2);
            chk_eq("first_acc_cycle", first_acc, 3);
            chk_eq("first_ov_cycle", first_ov, LEN_KIJ + 3);
            chk_eq("idle_after_done", {bus.CEN_pmem, bus.acc, bus.sfu_clr, bus.out_valid,
                                       bus.busy, bus.done}, 6'b100000);
            tick();
            chk_eq("still_idle", {bus.CEN_pmem, bus.acc, bus.sfu_clr, bus.out_valid,
                                  bus.busy, bus.done}, 6'b100000);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = a;
        tick();
        tick();
        check_idle("reset_state");
        bus.start = 1'b1;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check_idle("reset_beats_start");
        tick();
        check_idle("idle_no_start");

        run_pass(-1, 0, -1, -1, -1, -1, 1'b0);
        run_pass(3, 5, 2, -1, -1, -1, 1'b0);
        run_pass(-1, 0, -1, 50, 192, -1, 1'b0);
        run_pass(-1, 0, -1, -1, -1, 7, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 1024; a++) mem[a] = int'($urandom_range(0, 4095));
            run_pass(int'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 15)), int'($urandom_range(2, 150)),
                     -1, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
